// File: rtl/systolic_pkg.sv
// Shared constants and helpers for the systolic MAC array and its processing elements.
package systolic_pkg;

   localparam int DATA_W_DEF    = 16;
   localparam int ACC_W_DEF     = 40;
   localparam int W_CHAIN_DEPTH = 8;

   // Helpers return a wide vector; callers size-cast it down to their own ACC_W.
   localparam int ACC_W_MAX = 128;

   function automatic logic [ACC_W_MAX-1:0] acc_max(input int acc_w);
      acc_max = (ACC_W_MAX'(1) << (acc_w - 1)) - ACC_W_MAX'(1);
   endfunction

   function automatic logic [ACC_W_MAX-1:0] acc_min(input int acc_w);
      acc_min = ~acc_max(acc_w);
   endfunction

endpackage

// File: rtl/pe_sat_add.sv
// Combinational psum + product adder with overflow detect and optional saturation.
module pe_sat_add
   import systolic_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ACC_W  = ACC_W_DEF,
   parameter bit SAT_EN = 1'b1
) (
   input  logic signed [ACC_W-1:0]    i_psum,
   input  logic signed [2*DATA_W-1:0] i_prod,
   output logic signed [ACC_W-1:0]    o_sum,
   output logic                       o_ovf
);

   localparam logic signed [ACC_W-1:0] C_MAX = ACC_W'(acc_max(ACC_W));
   localparam logic signed [ACC_W-1:0] C_MIN = ACC_W'(acc_min(ACC_W));

   logic signed [ACC_W:0] w_sum;

   always_comb begin
      w_sum = (ACC_W+1)'(i_psum) + (ACC_W+1)'(i_prod);
      // The extra top bit disagrees with the ACC_W sign bit only when the sum does not fit.
      o_ovf = w_sum[ACC_W] ^ w_sum[ACC_W-1];
      o_sum = w_sum[ACC_W-1:0];
      if (o_ovf && SAT_EN) begin
         o_sum = w_sum[ACC_W] ? C_MIN : C_MAX;
      end
   end

endmodule

// File: rtl/systolic_pe_db.sv
// Weight-stationary systolic PE with a double-buffered weight (shadow chain + swap)
// and a saturating/wrapping accumulator path with a sticky overflow flag.
module systolic_pe_db
   import systolic_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ACC_W  = ACC_W_DEF,
   parameter bit SAT_EN = 1'b1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     compute,
   input  logic signed [DATA_W-1:0] act_in,
   input  logic                     act_valid_in,
   output logic signed [DATA_W-1:0] act_out,
   output logic                     act_valid_out,
   input  logic signed [ACC_W-1:0]  psum_in,
   output logic signed [ACC_W-1:0]  psum_out,
   input  logic signed [DATA_W-1:0] w_shift_in,
   input  logic                     w_shift_en,
   output logic signed [DATA_W-1:0] w_shift_out,
   input  logic                     w_swap,
   output logic                     ovf_sticky,
   input  logic                     ovf_clr
);

   if (ACC_W < 2*DATA_W) begin : g_bad_acc_w
      $error("systolic_pe_db: ACC_W must be at least 2*DATA_W");
   end

   logic signed [DATA_W-1:0]   r_act;
   logic                       r_act_valid;
   logic signed [ACC_W-1:0]    r_psum;
   logic signed [DATA_W-1:0]   r_shadow;
   logic signed [DATA_W-1:0]   r_active;
   logic                       r_ovf;

   logic signed [2*DATA_W-1:0] w_prod;
   logic signed [ACC_W-1:0]    w_sum;
   logic                       w_ovf;
   logic                       w_mac;

   // Both operands widened first so the full signed product is kept.
   assign w_prod = (2*DATA_W)'(act_in) * (2*DATA_W)'(r_active);
   assign w_mac  = compute & act_valid_in;

   pe_sat_add #(
      .DATA_W (DATA_W),
      .ACC_W  (ACC_W),
      .SAT_EN (SAT_EN)
   ) u_sat_add (
      .i_psum (psum_in),
      .i_prod (w_prod),
      .o_sum  (w_sum),
      .o_ovf  (w_ovf)
   );

   // Weight chain and swap run regardless of compute so the next tile loads during a stall.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_shadow <= '0;
         r_active <= '0;
      end else begin
         if (w_shift_en) r_shadow <= w_shift_in;
         if (w_swap)     r_active <= r_shadow;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_act       <= '0;
         r_act_valid <= 1'b0;
         r_psum      <= '0;
      end else if (compute) begin
         r_act       <= act_in;
         r_act_valid <= act_valid_in;
         r_psum      <= act_valid_in ? w_sum : psum_in;
      end
   end

   // A fresh overflow outranks a clear in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ovf <= 1'b0;
      end else if (w_mac && w_ovf) begin
         r_ovf <= 1'b1;
      end else if (ovf_clr) begin
         r_ovf <= 1'b0;
      end
   end

   assign act_out       = r_act;
   assign act_valid_out = r_act_valid;
   assign psum_out      = r_psum;
   assign w_shift_out   = r_shadow;
   assign ovf_sticky    = r_ovf;

endmodule

// File: tb/tb_systolic_pe_db.sv
// Scoreboard bench for systolic_pe_db: one saturating and one wrapping instance share stimulus.
module tb_systolic_pe_db;

   localparam int DW = 16;
   localparam int AW = 40;

   localparam logic signed [AW-1:0] MAX  = 40'sh7F_FFFF_FFFF;
   localparam logic signed [AW-1:0] MIN  = 40'sh80_0000_0000;
   localparam logic signed [AW-1:0] MIN6 = 40'sh80_0000_0006;
   localparam logic signed [AW-1:0] P30  = 40'sd1073741824;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic compute = 1'b0;
   logic signed [DW-1:0] act_in = '0;
   logic act_valid_in = 1'b0;
   logic signed [AW-1:0] psum_in = '0;
   logic signed [DW-1:0] w_shift_in = '0;
   logic w_shift_en = 1'b0;
   logic w_swap = 1'b0;
   logic ovf_clr = 1'b0;

   logic signed [DW-1:0] act_out_s, act_out_w, wso_s, wso_w;
   logic                 vld_s, vld_w, ovf_s, ovf_w;
   logic signed [AW-1:0] psum_s, psum_w;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic                 chk;
      logic signed [AW-1:0] p_sat;
      logic signed [AW-1:0] p_wrap;
      logic signed [DW-1:0] a;
      logic                 v;
      logic                 o;
      logic signed [DW-1:0] ws;
   } exp_t;

   exp_t exp_q[$];

   always #5 clk = ~clk;

   systolic_pe_db #(.DATA_W(DW), .ACC_W(AW), .SAT_EN(1'b1)) dut_sat (
      .clk(clk), .rst(rst), .compute(compute),
      .act_in(act_in), .act_valid_in(act_valid_in),
      .act_out(act_out_s), .act_valid_out(vld_s),
      .psum_in(psum_in), .psum_out(psum_s),
      .w_shift_in(w_shift_in), .w_shift_en(w_shift_en), .w_shift_out(wso_s),
      .w_swap(w_swap), .ovf_sticky(ovf_s), .ovf_clr(ovf_clr)
   );

   systolic_pe_db #(.DATA_W(DW), .ACC_W(AW), .SAT_EN(1'b0)) dut_wrap (
      .clk(clk), .rst(rst), .compute(compute),
      .act_in(act_in), .act_valid_in(act_valid_in),
      .act_out(act_out_w), .act_valid_out(vld_w),
      .psum_in(psum_in), .psum_out(psum_w),
      .w_shift_in(w_shift_in), .w_shift_en(w_shift_en), .w_shift_out(wso_w),
      .w_swap(w_swap), .ovf_sticky(ovf_w), .ovf_clr(ovf_clr)
   );

   task automatic cmp(input string name, input int idx, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s vec %0d got %0h expected %0h", name, idx, got, want);
      end
   endtask

   // Drive one cycle of inputs at the falling edge and queue what must appear after the next rising edge.
   task automatic step(input logic c, input logic signed [DW-1:0] a, input logic v,
                       input logic signed [AW-1:0] p, input logic signed [DW-1:0] ws,
                       input logic we, input logic sw, input logic clr, input logic r,
                       input logic signed [AW-1:0] e_ps, input logic signed [AW-1:0] e_pw,
                       input logic signed [DW-1:0] e_a, input logic e_v, input logic e_o,
                       input logic signed [DW-1:0] e_ws);
      exp_t e;
      @(negedge clk);
      compute = c; act_in = a; act_valid_in = v; psum_in = p;
      w_shift_in = ws; w_shift_en = we; w_swap = sw; ovf_clr = clr; rst = r;
      e.chk = 1'b1; e.p_sat = e_ps; e.p_wrap = e_pw; e.a = e_a; e.v = e_v; e.o = e_o; e.ws = e_ws;
      exp_q.push_back(e);
   endtask

   int vec = 0;

   always begin
      exp_t e;
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (e.chk) begin
            cmp("psum_sat",  vec, 64'(psum_s),    64'(e.p_sat));
            cmp("psum_wrap", vec, 64'(psum_w),    64'(e.p_wrap));
            cmp("act_out",   vec, 64'(act_out_s), 64'(e.a));
            cmp("act_valid", vec, 64'(vld_s),     64'(e.v));
            cmp("ovf_sat",   vec, 64'(ovf_s),     64'(e.o));
            cmp("ovf_wrap",  vec, 64'(ovf_w),     64'(e.o));
            cmp("w_shift",   vec, 64'(wso_s),     64'(e.ws));
            cmp("act_wrap",  vec, 64'({act_out_w, vld_w, wso_w}), 64'({e.a, e.v, e.ws}));
         end
         vec++;
      end
   end

   initial begin
      //   c  act    v  psum  wsin  we sw clr rst   psum_sat psum_wrap act  v ovf wso
      step(0, 0,     0, 0,    0,     0, 0, 0, 1,   0,    0,    0,     0, 0, 0);
      step(0, 0,     0, 0,    3,     1, 0, 0, 0,   0,    0,    0,     0, 0, 3);
      step(0, 0,     0, 0,    0,     0, 1, 0, 0,   0,    0,    0,     0, 0, 3);
      step(1, 5,     1, 100,  0,     0, 0, 0, 0,   115,  115,  5,     1, 0, 3);
      step(1, -2,    1, 0,    0,     0, 0, 0, 0,   -6,   -6,   -2,    1, 0, 3);
      step(0, 0,     0, 0,    -32768,1, 0, 0, 0,   -6,   -6,   -2,    1, 0, -32768);
      step(0, 0,     0, 0,    0,     0, 1, 0, 0,   -6,   -6,   -2,    1, 0, -32768);
      step(1, -32768,1, 0,    0,     0, 0, 0, 0,   P30,  P30,  -32768,1, 0, -32768);
      step(0, 0,     0, 0,    1,     1, 0, 0, 0,   P30,  P30,  -32768,1, 0, 1);
      step(0, 0,     0, 0,    0,     0, 1, 0, 0,   P30,  P30,  -32768,1, 0, 1);
      step(1, 1,     1, MAX,  0,     0, 0, 0, 0,   MAX,  MIN,  1,     1, 1, 1);
      step(1, -1,    1, MIN,  0,     0, 0, 0, 0,   MIN,  MAX,  -1,    1, 1, 1);
      step(1, 0,     0, 77,   0,     0, 0, 1, 0,   77,   77,   0,     0, 0, 1);
      step(0, 123,   1, 999,  0,     0, 0, 0, 0,   77,   77,   0,     0, 0, 1);
      step(0, -5,    0, MAX,  0,     0, 0, 0, 0,   77,   77,   0,     0, 0, 1);
      step(0, 1,     1, MAX,  0,     0, 0, 0, 0,   77,   77,   0,     0, 0, 1);
      step(0, 0,     0, 0,    3,     1, 0, 0, 0,   77,   77,   0,     0, 0, 3);
      step(0, 0,     0, 0,    0,     0, 1, 0, 0,   77,   77,   0,     0, 0, 3);
      step(0, 0,     0, 0,    7,     1, 0, 0, 0,   77,   77,   0,     0, 0, 7);
      step(1, 2,     1, 0,    9,     1, 1, 0, 0,   6,    6,    2,     1, 0, 9);
      step(1, 2,     1, 0,    0,     0, 0, 0, 0,   14,   14,   2,     1, 0, 9);
      step(1, 1,     1, MAX,  0,     0, 0, 1, 0,   MAX,  MIN6, 1,     1, 1, 9);
      step(0, 0,     0, 0,    0,     0, 0, 1, 0,   MAX,  MIN6, 1,     1, 0, 9);
      step(1, 4,     1, 50,   5,     1, 1, 0, 1,   0,    0,    0,     0, 0, 0);
      step(1, 4,     1, 50,   0,     0, 0, 0, 0,   50,   50,   4,     1, 0, 0);
      @(negedge clk);
      compute = 1'b0; act_valid_in = 1'b0; w_shift_en = 1'b0; w_swap = 1'b0; ovf_clr = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain pending %0d expected 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/systolic_pe_db.md
Name: systolic_pe_db

Overview:
Parametrised, double-buffered weight-stationary processing element for the systolic MAC array. It is the next generation of the fp32 PE: signed fixed-point datapath with configurable widths, a shadow weight register loaded through a north-to-south shift chain while the active weight keeps computing, per-lane valid propagation, and a saturating accumulator with a sticky overflow flag. Activations move west to east; partial sums move north to south.

Parameters:
DATA_W, 16, width of the signed activations and weights.
ACC_W, 40, width of the signed partial sum; must be >= 2*DATA_W (elaboration-time check).
SAT_EN, 1, 1 = clamp on overflow; 0 = two's-complement wrap.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
compute  in  1  datapath advance enable; 0 = stall
act_in  in  DATA_W  signed activation from west
act_valid_in  in  1  act_in qualifier
act_out  out  DATA_W  registered activation to east
act_valid_out  out  1  registered valid to east
psum_in  in  ACC_W  signed partial sum from north
psum_out  out  ACC_W  registered partial sum to south
w_shift_in  in  DATA_W  weight chain input from north
w_shift_en  in  1  shift-chain advance
w_shift_out  out  DATA_W  shadow weight, to south PE's w_shift_in
w_swap  in  1  copy shadow weight into active weight
ovf_sticky  out  1  overflow seen since last clear
ovf_clr  in  1  clear ovf_sticky

Behaviour:
- One clock (clk); reset synchronous, active-high (rst). All state updates on rising clk edges only.
- Reset: act_out, act_valid_out, psum_out, w_shift_out (shadow), active weight, ovf_sticky all 0 on the first edge with rst=1. This applies mid-operation too: rst has priority over every other input.
- Weight chain, independent of compute: if w_shift_en, shadow <= w_shift_in. w_shift_out is the shadow register, so an N-deep column loads in N cycles, last weight entered first.
- Swap, independent of compute: if w_swap, active <= shadow (value before this edge). With w_shift_en and w_swap in the same cycle, active gets the old shadow and shadow gets w_shift_in. The new active weight is used for products evaluated from the next cycle.
- Datapath, compute=1:
  - act_out <= act_in; act_valid_out <= act_valid_in.
  - If act_valid_in: psum_out <= f(psum_in + sext(act_in*active)). The product is full 2*DATA_W signed, sign-extended to ACC_W. The sum is formed at ACC_W+1 bits.
  - If act_valid_in=0: psum_out <= psum_in (pass-through, no overflow check).
  - Latency is 1 cycle for both activation and psum.
- Datapath, compute=0: act_out, act_valid_out and psum_out hold. The overflow flag is not updated.
- Overflow: the ACC_W+1 sum does not fit ACC_W.
  - SAT_EN=1: clamp to +(2^(ACC_W-1)-1) or -2^(ACC_W-1).
  - SAT_EN=0: keep the low ACC_W bits.
  - In both modes ovf_sticky <= 1.
- ovf_clr clears ovf_sticky. An overflow in the same cycle wins (flag stays 1).
- No combinational path from any input to any output.

Decomposition:
- Package systolic_pkg: default DATA_W/ACC_W constants, signed max/min constant functions of ACC_W, and a shared weight-chain-depth constant for the array wrapper.
- One sub-module: pe_sat_add. It is combinational, takes ACC_W psum and 2*DATA_W product and SAT_EN, and returns the ACC_W result plus an overflow bit. It is reused later by the array's edge accumulators.
- Everything else (registers, chain, swap) stays in systolic_pe_db.

Test Plan:
- Reset then load/swap: rst 1 cycle; w_shift_en with w_shift_in=3 for 1 cycle, then w_swap; act_in=5 valid, psum_in=100, compute=1 -> next cycle psum_out=115, act_out=5, act_valid_out=1.
- Signed multiply: active=3, act_in=-2, psum_in=0 -> psum_out=-6. Then act_in=-32768, active=-32768, psum_in=0 -> psum_out=1073741824, no overflow.
- Saturation: SAT_EN=1, psum_in=2^39-1, act_in=1, active=1 -> psum_out=2^39-1, ovf_sticky=1. psum_in=-2^39, act=-1, w=1 -> psum_out=-2^39. With SAT_EN=0 the first case gives psum_out=-2^39, ovf_sticky=1.
- Stall and invalid: compute=0 for 3 cycles with changing inputs -> outputs unchanged. act_valid_in=0, psum_in=77 -> psum_out=77 regardless of weight.
- Simultaneous shift+swap during compute: shadow=7, active=3, then w_shift_in=9 with w_shift_en=w_swap=1 and act_in=2 valid, psum_in=0 -> that cycle's psum_out=6. Active=7, shadow=9, and the next valid act_in=2 gives 14.
- Clear/reset priority: ovf_clr and a new overflow in the same cycle -> ovf_sticky=1. ovf_clr alone -> 0. rst asserted mid-stream -> all outputs 0 on the next edge.
